// File: rtl/alu_status.sv
// alu_status: processor P register (N V 1 1 D I Z C); 1-cycle latency from any enable to p.
// No backpressure: never stalls, every input is consumed on the edge it is presented.
module alu_status #(
    parameter logic [7:0] RESET_P = 8'h34,
    parameter bit         DELAY_I = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       nz_we,
    input  logic       c_we,
    input  logic       v_we,
    input  logic       bit_we,
    input  logic [7:0] bit_src,
    input  logic [3:0] flag_op,
    input  logic       plp_we,
    input  logic [7:0] plp_data,
    input  logic       brk,
    input  logic       instr_done,
    output logic [7:0] p,
    output logic [7:0] p_push,
    output logic       c_flag,
    output logic       d_flag,
    output logic       irq_mask
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_CLC  = 4'd1,
        OP_SEC  = 4'd2,
        OP_CLI  = 4'd3,
        OP_SEI  = 4'd4,
        OP_CLD  = 4'd5,
        OP_SED  = 4'd6,
        OP_CLV  = 4'd7,
        OP_IRQ  = 4'd8
    } flag_op_e;

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
    logic w_alu_zero;
    logic w_irq_entry;
    logic w_unused_plp;

    assign w_alu_zero   = (alu_out == 8'h00);
    assign w_irq_entry  = (flag_op == OP_IRQ);
    // Stacked B and bit-5 positions carry no state here.
    assign w_unused_plp = &{1'b0, plp_data[5:4]};

    // Later assignments override earlier ones, so writes are ordered lowest
    // priority first; each flag only sees writers that target it.
    always_comb begin
        w_n_nxt = r_n;
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        w_i_nxt = r_i;
        w_z_nxt = r_z;
        w_c_nxt = r_c;

        if (nz_we) begin
            w_n_nxt = alu_out[7];
            w_z_nxt = w_alu_zero;
        end
        if (c_we) begin
            w_c_nxt = alu_c;
        end
        if (v_we) begin
            w_v_nxt = alu_v;
        end

        if (bit_we) begin
            w_n_nxt = bit_src[7];
            w_v_nxt = bit_src[6];
            w_z_nxt = w_alu_zero;
        end

        case (flag_op)
            OP_CLC:  w_c_nxt = 1'b0;
            OP_SEC:  w_c_nxt = 1'b1;
            OP_CLI:  w_i_nxt = 1'b0;
            OP_SEI:  w_i_nxt = 1'b1;
            OP_CLD:  w_d_nxt = 1'b0;
            OP_SED:  w_d_nxt = 1'b1;
            OP_CLV:  w_v_nxt = 1'b0;
            OP_IRQ:  w_i_nxt = 1'b1;
            default: ;
        endcase

        if (plp_we) begin
            w_n_nxt = plp_data[7];
            w_v_nxt = plp_data[6];
            w_d_nxt = plp_data[3];
            w_i_nxt = plp_data[2];
            w_z_nxt = plp_data[1];
            w_c_nxt = plp_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n <= RESET_P[7];
            r_v <= RESET_P[6];
            r_d <= RESET_P[3];
            r_i <= RESET_P[2];
            r_z <= RESET_P[1];
            r_c <= RESET_P[0];
        end else begin
            r_n <= w_n_nxt;
            r_v <= w_v_nxt;
            r_d <= w_d_nxt;
            r_i <= w_i_nxt;
            r_z <= w_z_nxt;
            r_c <= w_c_nxt;
        end
    end

    generate
        if (DELAY_I) begin : g_delayed_mask
            logic r_irq_mask;

            // Mask tracks I only at instruction boundaries, except that taking
            // an interrupt must mask further interrupts immediately.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_irq_mask <= 1'b1;
                end else if (w_irq_entry) begin
                    r_irq_mask <= 1'b1;
                end else if (instr_done) begin
                    r_irq_mask <= w_i_nxt;
                end
            end

            assign irq_mask = r_irq_mask;
        end else begin : g_direct_mask
            assign irq_mask = r_i;
        end
    endgenerate

    assign p      = {r_n, r_v, 1'b1, 1'b1, r_d, r_i, r_z, r_c};
    assign p_push = {r_n, r_v, 1'b1, brk,  r_d, r_i, r_z, r_c};
    assign c_flag = r_c;
    assign d_flag = r_d;

endmodule
